// File: rtl/palette_pkg.sv
// Shared types and constants for the palette video output stage:
// FSM states, luma weights and the built-in 16-entry default palette.
package palette_pkg;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} pal_state_t;

   // Luma approximation y = (2R + 5G + B) >> 3
   localparam int LUMA_R  = 2;
   localparam int LUMA_G  = 5;
   localparam int LUMA_B  = 1;
   localparam int LUMA_SH = 3;

   // Channel width the default table is authored in
   localparam int BASE_CH_W = 6;

   // Default EG2000-style palette, {R,G,B} at 6 bits per channel.
   // Larger index widths wrap onto the same 16 colours.
   function automatic logic [3*BASE_CH_W-1:0] pal_default(input int unsigned idx);
      logic [3*BASE_CH_W-1:0] e;
      case (idx % 16)
         0:       e = {6'h17, 6'h17, 6'h17};
         1:       e = {6'h3F, 6'h0C, 6'h0C};
         2:       e = {6'h0C, 6'h3F, 6'h0C};
         3:       e = {6'h3A, 6'h3A, 6'h3A};
         4:       e = {6'h0C, 6'h0C, 6'h3F};
         5:       e = {6'h3F, 6'h3F, 6'h0C};
         6:       e = {6'h0C, 6'h3F, 6'h3F};
         7:       e = {6'h3F, 6'h0C, 6'h3F};
         8:       e = {6'h25, 6'h25, 6'h25};
         9:       e = {6'h2A, 6'h15, 6'h00};
         10:      e = {6'h15, 6'h2A, 6'h00};
         11:      e = {6'h00, 6'h15, 6'h2A};
         12:      e = {6'h30, 6'h20, 6'h10};
         13:      e = {6'h10, 6'h20, 6'h30};
         14:      e = {6'h20, 6'h10, 6'h30};
         default: e = {6'h3F, 6'h3F, 6'h3F};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/palette_video_out_if.sv
// Bundles the core-side video inputs, host palette port and VGA-side outputs.
// master = core/host side, slave = palette_video_out.
interface palette_video_out_if #(
   parameter int IDX_W = 4,
   parameter int CH_W  = 6,
   parameter int OUT_W = 8
);
   logic                ce_pix;
   logic                pixel;
   logic [IDX_W-1:0]    color;
   logic                hs, vs, hb, vb;
   logic                mono;
   logic                pal_wr;
   logic [IDX_W-1:0]    pal_addr;
   logic [3*CH_W-1:0]   pal_data;
   logic                pal_busy;
   logic [OUT_W-1:0]    VGA_R, VGA_G, VGA_B;
   logic                VGA_HS, VGA_VS, VGA_HB, VGA_VB;
   logic                CE_PIXEL;

   modport master (
      output ce_pix, pixel, color, hs, vs, hb, vb, mono, pal_wr, pal_addr, pal_data,
      input  pal_busy, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_HB, VGA_VB, CE_PIXEL
   );

   modport slave (
      input  ce_pix, pixel, color, hs, vs, hb, vb, mono, pal_wr, pal_addr, pal_data,
      output pal_busy, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_HB, VGA_VB, CE_PIXEL
   );
endinterface

// File: rtl/palette_ram.sv
// 1W/1R synchronous palette RAM. Read-first: a same-cycle write to the
// address being read returns the old entry.
module palette_ram #(
   parameter int AW = 4,
   parameter int DW = 18
) (
   input  logic          clk_sys,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [2**AW];

   // Write port and registered read of the pre-write contents
   always_ff @(posedge clk_sys) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/palette_video_out.sv
// Palette lookup video output: default-reload FSM, power-on hold counter,
// and a fixed 2-cycle pipeline (RAM read, then scale/mono/blank).
module palette_video_out
   import palette_pkg::*;
#(
   parameter int IDX_W   = 4,
   parameter int CH_W    = 6,
   parameter int OUT_W   = 8,
   parameter int POR_CYC = 32
) (
   input  logic              clk_sys,
   input  logic              reset,
   palette_video_out_if.slave bus,
   output logic              power_ok
);
   localparam int DEPTH = 2**IDX_W;
   localparam int EW    = 3*CH_W;
   localparam int PW    = $clog2(POR_CYC+1);
   localparam int LW    = CH_W+3;
   localparam int REP6  = CH_W/BASE_CH_W + 1;
   localparam int REPO  = OUT_W/CH_W + 1;

   // Map a 6-bit table channel onto CH_W bits (truncate or MSB-replicate)
   function automatic logic [CH_W-1:0] fit_ch(input logic [BASE_CH_W-1:0] c);
      return CH_W'({REP6{c}} >> (REP6*BASE_CH_W - CH_W));
   endfunction

   function automatic logic [EW-1:0] default_entry(input int unsigned idx);
      logic [3*BASE_CH_W-1:0] e6;
      e6 = pal_default(idx);
      return {fit_ch(e6[17:12]), fit_ch(e6[11:6]), fit_ch(e6[5:0])};
   endfunction

   // Widen a channel to OUT_W by repeating its MSBs into the low bits
   function automatic logic [OUT_W-1:0] scale(input logic [CH_W-1:0] c);
      return OUT_W'({REPO{c}} >> (REPO*CH_W - OUT_W));
   endfunction

   pal_state_t       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_init_ptr, w_init_ptr_nxt;
   logic             w_busy;
   logic             w_we;
   logic [IDX_W-1:0] w_waddr;
   logic [EW-1:0]    w_wdata;
   logic [EW-1:0]    w_rdata;
   logic [PW-1:0]    r_por_cnt;

   logic r_s1_pixel, r_s1_mono, r_s1_busy;
   logic r_s1_hs, r_s1_vs, r_s1_hb, r_s1_vb, r_s1_ce;

   logic [CH_W-1:0] w_ch_r, w_ch_g, w_ch_b, w_y;
   logic [LW-1:0]   w_luma_sum;
   logic            w_blank;

   // Reload FSM state register; reset always restarts the reload from entry 0
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state    <= INIT;
         r_init_ptr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_ptr <= w_init_ptr_nxt;
      end
   end

   // Next-state: walk every entry once, then hand the RAM to the host
   always_comb begin
      w_state_nxt    = r_state;
      w_init_ptr_nxt = r_init_ptr;
      case (r_state)
         INIT: begin
            w_init_ptr_nxt = r_init_ptr + 1'b1;
            if (r_init_ptr == IDX_W'(DEPTH-1)) begin
               w_state_nxt    = RUN;
               w_init_ptr_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   assign w_busy       = (r_state == INIT);
   assign bus.pal_busy = w_busy;

   // Write port mux: defaults during reload, host writes otherwise
   always_comb begin
      w_we    = !reset && (w_busy || bus.pal_wr);
      w_waddr = bus.pal_addr;
      w_wdata = bus.pal_data;
      if (w_busy) begin
         w_waddr = r_init_ptr;
         w_wdata = default_entry(32'(r_init_ptr));
      end
   end

   palette_ram #(.AW(IDX_W), .DW(EW)) u_ram (
      .clk_sys (clk_sys),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (bus.color),
      .o_rdata (w_rdata)
   );

   // Power-on hold counter, saturates at POR_CYC
   always_ff @(posedge clk_sys) begin
      if (reset)                          r_por_cnt <= '0;
      else if (r_por_cnt != PW'(POR_CYC)) r_por_cnt <= r_por_cnt + 1'b1;
   end

   assign power_ok = (r_por_cnt == PW'(POR_CYC));

   // Stage 1: align controls and syncs with the RAM read data
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         {r_s1_pixel, r_s1_mono, r_s1_busy} <= '0;
         {r_s1_hs, r_s1_vs, r_s1_hb, r_s1_vb, r_s1_ce} <= '0;
      end else begin
         r_s1_pixel <= bus.pixel;
         r_s1_mono  <= bus.mono;
         r_s1_busy  <= w_busy;
         r_s1_hs    <= bus.hs;
         r_s1_vs    <= bus.vs;
         r_s1_hb    <= bus.hb;
         r_s1_vb    <= bus.vb;
         r_s1_ce    <= bus.ce_pix;
      end
   end

   assign w_ch_r     = w_rdata[EW-1 -: CH_W];
   assign w_ch_g     = w_rdata[2*CH_W-1 -: CH_W];
   assign w_ch_b     = w_rdata[CH_W-1:0];
   assign w_luma_sum = LW'(LUMA_R) * LW'(w_ch_r) + LW'(LUMA_G) * LW'(w_ch_g)
                     + LW'(LUMA_B) * LW'(w_ch_b);
   assign w_y        = CH_W'(w_luma_sum >> LUMA_SH);
   assign w_blank    = !r_s1_pixel || r_s1_hb || r_s1_vb || r_s1_busy;

   // Stage 2: scale/mono/blank into the output registers, syncs follow
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         bus.VGA_R <= '0;
         bus.VGA_G <= '0;
         bus.VGA_B <= '0;
         {bus.VGA_HS, bus.VGA_VS, bus.VGA_HB, bus.VGA_VB, bus.CE_PIXEL} <= '0;
      end else begin
         if (w_blank) begin
            bus.VGA_R <= '0;
            bus.VGA_G <= '0;
            bus.VGA_B <= '0;
         end else if (r_s1_mono) begin
            bus.VGA_R <= scale(w_y);
            bus.VGA_G <= scale(w_y);
            bus.VGA_B <= scale(w_y);
         end else begin
            bus.VGA_R <= scale(w_ch_r);
            bus.VGA_G <= scale(w_ch_g);
            bus.VGA_B <= scale(w_ch_b);
         end
         bus.VGA_HS   <= r_s1_hs;
         bus.VGA_VS   <= r_s1_vs;
         bus.VGA_HB   <= r_s1_hb;
         bus.VGA_VB   <= r_s1_vb;
         bus.CE_PIXEL <= r_s1_ce;
      end
   end
endmodule

// File: tb/tb_palette_video_out.sv
// Bench for palette_video_out: a palette/queue model checked every cycle,
// plus directed literal expectations at key points.
module tb_palette_video_out;
   localparam int IDX_W = 4, CH_W = 6, OUT_W = 8, POR_CYC = 32;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   logic power_ok;

   always #5 clk_sys = ~clk_sys;

   palette_video_out_if #(.IDX_W(IDX_W), .CH_W(CH_W), .OUT_W(OUT_W)) vif();

   palette_video_out #(.IDX_W(IDX_W), .CH_W(CH_W), .OUT_W(OUT_W), .POR_CYC(POR_CYC)) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .bus      (vif.slave),
      .power_ok (power_ok)
   );

   typedef struct packed {
      logic [7:0] r, g, b;
      logic       hs, vs, hb, vb, ce;
   } vout_t;

   logic [17:0] def_pal [16] = '{
      {6'h17,6'h17,6'h17}, {6'h3F,6'h0C,6'h0C}, {6'h0C,6'h3F,6'h0C}, {6'h3A,6'h3A,6'h3A},
      {6'h0C,6'h0C,6'h3F}, {6'h3F,6'h3F,6'h0C}, {6'h0C,6'h3F,6'h3F}, {6'h3F,6'h0C,6'h3F},
      {6'h25,6'h25,6'h25}, {6'h2A,6'h15,6'h00}, {6'h15,6'h2A,6'h00}, {6'h00,6'h15,6'h2A},
      {6'h30,6'h20,6'h10}, {6'h10,6'h20,6'h30}, {6'h20,6'h10,6'h30}, {6'h3F,6'h3F,6'h3F}};

   int    pr [16], pg [16], pb [16];
   int    busy_left = 0;
   int    por       = 0;
   bit    mdl_valid = 0;
   vout_t q [$];
   int    checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // 6-bit channel to 8 bits: shift up and fill with the top bits
   function automatic int up8(input int c);
      return c * 4 + c / 16;
   endfunction

   function automatic vout_t model_px(input int idx, input bit pix, input bit mono,
                                      input bit hs, input bit vs, input bit hb,
                                      input bit vb, input bit ce, input bit busy);
      vout_t o;
      int    y;
      o    = '0;
      o.hs = hs; o.vs = vs; o.hb = hb; o.vb = vb; o.ce = ce;
      if (pix && !hb && !vb && !busy) begin
         if (mono) begin
            y   = (2 * pr[idx] + 5 * pg[idx] + pb[idx]) / 8;
            o.r = 8'(up8(y)); o.g = 8'(up8(y)); o.b = 8'(up8(y));
         end else begin
            o.r = 8'(up8(pr[idx])); o.g = 8'(up8(pg[idx])); o.b = 8'(up8(pb[idx]));
         end
      end
      return o;
   endfunction

   // Model: outputs after an edge are the lookup of inputs seen one edge earlier
   always @(posedge clk_sys) begin
      vout_t e;
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            pr[i] = int'(def_pal[i][17:12]);
            pg[i] = int'(def_pal[i][11:6]);
            pb[i] = int'(def_pal[i][5:0]);
         end
         busy_left = 16;
         por       = 0;
         q.delete();
         q.push_back('0);
         q.push_back('0);
         mdl_valid = 1;
      end else if (mdl_valid) begin
         e = model_px(int'(vif.color), vif.pixel, vif.mono, vif.hs, vif.vs,
                      vif.hb, vif.vb, vif.ce_pix, busy_left > 0);
         if (busy_left > 0) busy_left--;
         else if (vif.pal_wr) begin
            pr[vif.pal_addr] = int'(vif.pal_data[17:12]);
            pg[vif.pal_addr] = int'(vif.pal_data[11:6]);
            pb[vif.pal_addr] = int'(vif.pal_data[5:0]);
         end
         if (por < POR_CYC) por++;
         void'(q.pop_front());
         q.push_back(e);
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk_sys) begin
      if (mdl_valid) begin
         chk("rgb", {vif.VGA_R, vif.VGA_G, vif.VGA_B}, {q[0].r, q[0].g, q[0].b});
         chk("syncs", {vif.VGA_HS, vif.VGA_VS, vif.VGA_HB, vif.VGA_VB, vif.CE_PIXEL},
             {q[0].hs, q[0].vs, q[0].hb, q[0].vb, q[0].ce});
         chk("pal_busy", 32'(vif.pal_busy), 32'(busy_left > 0));
         chk("power_ok", 32'(power_ok), 32'(por >= POR_CYC));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   function automatic logic [23:0] rgb();
      return {vif.VGA_R, vif.VGA_G, vif.VGA_B};
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vif.ce_pix = 0; vif.pixel = 0; vif.color = '0; vif.mono = 0;
      vif.hs = 0; vif.vs = 0; vif.hb = 0; vif.vb = 0;
      vif.pal_wr = 0; vif.pal_addr = '0; vif.pal_data = '0;
      reset = 1;
      tick(2);
      reset = 0;

      // Reload and power-on hold timing from reset release
      for (int k = 1; k <= 32; k++) begin
         tick(1);
         if (k == 1)  chk("rst_rgb", 32'(rgb()), 32'h0);
         if (k == 15) chk("busy_15", 32'(vif.pal_busy), 32'h1);
         if (k == 16) chk("busy_16", 32'(vif.pal_busy), 32'h0);
         if (k == 31) chk("por_31", 32'(power_ok), 32'h0);
         if (k == 32) chk("por_32", 32'(power_ok), 32'h1);
      end

      // Default palette lookups
      vif.pixel = 1; vif.ce_pix = 1; vif.color = 4'd15;
      tick(2); chk("c15", 32'(rgb()), 32'hFFFFFF);
      vif.color = 4'd0;
      tick(2); chk("c0", 32'(rgb()), 32'h5D5D5D);

      // Same-cycle write and read of entry 3: old value first
      vif.color = 4'd3; vif.pal_wr = 1; vif.pal_addr = 4'd3;
      vif.pal_data = {6'h3F, 6'h00, 6'h00};
      tick(1); vif.pal_wr = 0;
      tick(1); chk("rd_old", 32'(rgb()), 32'hEBEBEB);
      tick(1); chk("rd_new", 32'(rgb()), 32'hFF0000);

      // Mono
      vif.mono = 1;
      tick(2); chk("mono3", 32'(rgb()), 32'h3C3C3C);
      vif.color = 4'd15;
      tick(2); chk("mono15", 32'(rgb()), 32'hFFFFFF);
      vif.mono = 0;

      // Blanking with syncs passing through, 2-cycle delay
      vif.hb = 1; vif.hs = 1;
      tick(1); chk("hb_d1", 32'(vif.VGA_HB), 32'h0);
      tick(1); chk("hb_d2", 32'(vif.VGA_HB), 32'h1);
      chk("hs_d2", 32'(vif.VGA_HS), 32'h1);
      chk("hb_black", 32'(rgb()), 32'h0);
      vif.hb = 0; vif.hs = 0; vif.pixel = 0;
      tick(2); chk("pix_off", 32'(rgb()), 32'h0);
      vif.pixel = 1; vif.ce_pix = 0;
      tick(1); chk("ce_d1", 32'(vif.CE_PIXEL), 32'h1);
      tick(1); chk("ce_d2", 32'(vif.CE_PIXEL), 32'h0);

      // Mixed traffic, checked by the model each cycle
      for (int i = 0; i < 48; i++) begin
         vif.color  = 4'(i % 16);
         vif.pixel  = (i % 7) != 0;
         vif.hs     = (i % 4) >= 2;
         vif.vs     = (i == 20);
         vif.hb     = (i % 11) == 0;
         vif.vb     = (i % 13) == 5;
         vif.mono   = ((i / 16) % 2) == 1;
         vif.ce_pix = (i % 2) == 1;
         vif.pal_wr = (i % 5) == 0;
         vif.pal_addr = 4'((i * 3) % 16);
         vif.pal_data = {6'(i), 6'(63 - i), 6'(i * 5)};
         tick(1);
      end
      vif.pal_wr = 0; vif.hb = 0; vif.vb = 0; vif.pixel = 1; vif.mono = 0;
      vif.hs = 0; vif.vs = 0;

      // Host write, then reset; then a second reset at reload cycle 8
      vif.pal_wr = 1; vif.pal_addr = 4'd15; vif.pal_data = {6'h01, 6'h02, 6'h03};
      vif.color = 4'd15;
      tick(1); vif.pal_wr = 0;
      tick(2); chk("host15", 32'(rgb()), 32'h04080C);
      reset = 1;
      tick(1); reset = 0;
      vif.pal_wr = 1; vif.pal_addr = 4'd0; vif.pal_data = '0;
      tick(8);
      reset = 1;
      tick(1); reset = 0;
      for (int k = 1; k <= 16; k++) begin
         vif.pal_addr = 4'(k);
         tick(1);
         if (k == 15) chk("rbusy_15", 32'(vif.pal_busy), 32'h1);
         if (k == 16) chk("rbusy_16", 32'(vif.pal_busy), 32'h0);
      end
      vif.pal_wr = 0;
      tick(2); chk("restored15", 32'(rgb()), 32'hFFFFFF);
      vif.color = 4'd0;
      tick(2); chk("restored0", 32'(rgb()), 32'h5D5D5D);
      vif.color = 4'd1;
      tick(2); chk("restored1", 32'(rgb()), 32'hFF3030);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
